// File: rtl/coin_pkg.sv
// Shared constants for the coin input front end: coin width, coin values and
// debounce defaults, plus a small press-count helper used by the arbiter.
package coin_pkg;

    localparam int COIN_W = 6;

    localparam logic [COIN_W-1:0] COIN_5_VAL  = 6'd5;
    localparam logic [COIN_W-1:0] COIN_10_VAL = 6'd10;
    localparam logic [COIN_W-1:0] COIN_25_VAL = 6'd25;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT           = 3;

    // Number of channels reporting a press in the same cycle (0..3).
    function automatic logic [1:0] press_count(input logic [2:0] presses);
        return {1'b0, presses[0]} + {1'b0, presses[1]} + {1'b0, presses[2]};
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchroniser, stable-level debounce counter and a
// single-cycle rising-press strobe.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             st_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw button and track its debounced level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            st_r   <= 1'b0;
            cnt_r  <= '0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
            if (sync_r == st_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                st_r  <= sync_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Fires in the cycle the stable level is about to rise; releases give nothing.
    assign press = (sync_r != st_r) && (cnt_r == CNT_MAX) && sync_r;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin front end: three debounced channels, simultaneous-press rejection and a
// depth-1 valid/ack hold register feeding the coin-accumulate FSM.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              coin_5,
    input  logic              coin_10,
    input  logic              coin_25,
    input  logic              coin_ack,
    output logic              coin_valid,
    output logic [COIN_W-1:0] coin_val,
    output logic              coin_reject,
    output logic              coin_overrun
);

    logic [2:0]        presses_s;
    logic              accept_s;
    logic              multi_s;
    logic              free_s;
    logic [COIN_W-1:0] value_s;

    logic              valid_r;
    logic [COIN_W-1:0] val_r;
    logic              reject_r;
    logic              overrun_r;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_5 (
        .CLK(CLK), .RST(RST), .raw(coin_5), .press(presses_s[0])
    );
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_10 (
        .CLK(CLK), .RST(RST), .raw(coin_10), .press(presses_s[1])
    );
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_25 (
        .CLK(CLK), .RST(RST), .raw(coin_25), .press(presses_s[2])
    );

    // Arbitrate: only a lone press is accepted, and it selects the coin value.
    always_comb begin
        accept_s = 1'b0;
        value_s  = '0;
        multi_s  = (press_count(presses_s) > 2'd1);
        case (presses_s)
            3'b001: begin
                accept_s = 1'b1;
                value_s  = COIN_5_VAL;
            end
            3'b010: begin
                accept_s = 1'b1;
                value_s  = COIN_10_VAL;
            end
            3'b100: begin
                accept_s = 1'b1;
                value_s  = COIN_25_VAL;
            end
            default: begin
                accept_s = 1'b0;
                value_s  = '0;
            end
        endcase
    end

    // An ack in the same cycle frees the slot so a new coin can load without a gap.
    assign free_s = !valid_r || coin_ack;

    // Hold register plus the reject and overrun pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r   <= 1'b0;
            val_r     <= '0;
            reject_r  <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            reject_r  <= multi_s;
            overrun_r <= accept_s && !free_s;
            if (accept_s && free_s) begin
                valid_r <= 1'b1;
                val_r   <= value_s;
            end else if (valid_r && coin_ack) begin
                valid_r <= 1'b0;
                val_r   <= '0;
            end else begin
                valid_r <= valid_r;
                val_r   <= val_r;
            end
        end
    end

    assign coin_valid   = valid_r;
    assign coin_val     = val_r;
    assign coin_reject  = reject_r;
    assign coin_overrun = overrun_r;

endmodule
